pkt_buffer_write_arbiter: RTL and testbench
===========================================

// Module: pkt_buffer_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single packet-buffer write port (134b data, 16b addr, wr/ack) among NUM_REQ
//  packet-map/dispatch requesters (host rx, network rx ports). Grant locks for a whole packet (head..tail);
//  watchdog releases a stalled grant. Sits between the per-port map/dispatch blocks and the packet buffer.
// PARAMETERS
//  NUM_REQ        3      number of requesters (2..8)
//  TIMEOUT_CYCLES 16'd64 idle cycles of granted requester mid-packet before grant is released (>=1)
// PORTS
//  i_clk             in   1            system clock
//  i_rst             in   1            synchronous reset, active-high
//  iv_wdata          in   NUM_REQ*134  beat per requester; [133:132] flag: 01 head, 11 middle, 10 tail
//  iv_data_waddr     in   NUM_REQ*16   buffer write address per requester
//  iv_data_wr        in   NUM_REQ      beat valid per requester; held with data until acked
//  ov_wdata_ack      out  NUM_REQ      1-cycle pulse: requester's beat captured this cycle
//  ov_wdata          out  134          beat to packet buffer
//  ov_data_waddr     out  16           address to packet buffer
//  o_data_wr         out  1            beat valid; held until i_wdata_ack
//  i_wdata_ack       in   1            packet buffer accepted current beat
//  ov_grant          out  3            index of current/last granted requester
//  o_timeout_pulse   out  1            grant released by watchdog
//  o_discard_pulse   out  1            stray non-head beat dropped in IDLE
//  arb_state         out  2            FSM state for debug
// BEHAVIOUR
//  Reset: all outputs 0, arb_state=IDLE, rr pointer=NUM_REQ-1 (req0 wins first), watchdog=0. Reset mid-packet
//   drops the output beat and grant; no tail is synthesised.
//  Output register: may capture when o_data_wr=0 or i_wdata_ack=1 in the same cycle ("slot free"). Capture
//   sets o_data_wr=1 next cycle with the selected beat/addr and pulses ov_wdata_ack[g] in the capture cycle.
//   i_wdata_ack with no new capture clears o_data_wr. Latency iv_data_wr -> o_data_wr: 1 cycle.
//   Path i_wdata_ack -> ov_wdata_ack is combinational (by design, no skid buffer).
//  Requester rule: after the ov_wdata_ack pulse, present the next beat or drop wr the following cycle.
//  FSM states: IDLE(0), XFER(1).
//   IDLE: scan from pointer+1 modulo NUM_REQ for first req with wr=1 and flag=01; if slot free, capture it,
//    ov_grant=g, go XFER. Any req with wr=1 and flag!=01 is acked and dropped (o_discard_pulse, one per cycle,
//    lowest index first); discard has priority over head selection for that requester only.
//   XFER: only req g is served; others get no ack. Beat from g captured when slot free; flag=10 captured ->
//    pointer=g, go IDLE (new head may be selected the next cycle). Flag=01 from g in XFER is treated as a
//    new packet start: forwarded, grant kept.
//  Watchdog (16b): in XFER, increments each cycle g has wr=0; cleared on every capture from g and in IDLE.
//   Reaching TIMEOUT_CYCLES -> o_timeout_pulse 1 cycle, pointer=g, go IDLE. A beat still in the output
//   register completes normally. Counter saturates, no wrap.
//  Backpressure: while i_wdata_ack=0 and o_data_wr=1, ov_wdata/ov_data_waddr stay stable; no requester acked;
//   watchdog does not count (g has wr=1).
//  Simultaneous: capture and i_wdata_ack in the same cycle -> o_data_wr stays 1 with the new beat.
// STRUCTURE
//  Shared include (pkt_arb_defines.v): flag codes HEAD/MID/TAIL, beat width 134, addr width 16, FSM encodings.
//  One sub-module: rr_select (NUM_REQ-bit request vector + pointer -> one-hot grant + index), combinational.
//  Top: FSM, pointer, watchdog, output register, ack decode.
// TESTING
//  1 After reset req0,req1 raise 4-beat heads same cycle, ack always 1 -> req0 beats on cycles 1-4, req1 cycles 5-8.
//  2 Grant locked on req2, i_wdata_ack low 3 cycles -> o_data_wr=1, data/addr stable, ov_wdata_ack=0 for 3 cycles.
//  3 TIMEOUT_CYCLES=8, req1 stops after 2 beats -> o_timeout_pulse on 8th idle cycle; next cycle req2 head granted.
//  4 IDLE, req1 presents flag=11 beat -> ov_wdata_ack[1]=1, o_discard_pulse=1, o_data_wr stays 0.
//  5 i_rst during beat 2 of req0 packet -> next cycle all outputs 0, arb_state=0; req1 head then granted first.
//  6 NUM_REQ=3, all requesters stream 4-beat packets continuously -> grant order 0,1,2,0,1,2, no gaps at ack=1.

Source files
------------

// File: rtl/pkt_buffer_write_arbiter_pkg.sv
// Shared definitions for the packet-buffer write arbiter.
//   BEAT_W / ADDR_W : packet-buffer beat and address widths
//   IDX_W           : width of a requester index (up to 8 requesters)
//   WD_W            : width of the stalled-grant watchdog counter
//   FLAG_*          : beat position codes carried in beat[133:132]
//   arb_state_e     : arbiter FSM encoding, visible on the debug port
package pkt_buffer_write_arbiter_pkg;

  localparam int BEAT_W = 134;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = 3;
  localparam int WD_W   = 16;

  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_MID  = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1
  } arb_state_e;

  // Position flag sits in the two most significant bits of a beat.
  function automatic logic [1:0] beat_flag(input logic [BEAT_W-1:0] beat);
    return beat[BEAT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pkt_buffer_write_arbiter_rr_select.sv
// Round-robin selector: picks the first asserted request strictly after the
// pointer, wrapping modulo NUM_REQ.  Purely combinational.
//   req       : request vector, one bit per requester
//   ptr       : index of the requester served last
//   grant_oh  : one-hot winner (all zero when nothing requests)
//   grant_idx : binary index of the winner
//   grant_any : at least one request is asserted
module pkt_buffer_write_arbiter_rr_select
  import pkt_buffer_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic found;

  // Two passes replace the modulo scan: first requesters above the pointer,
  // then wrap around to the lowest index (which includes the pointer itself).
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) > ptr)) begin
        grant_oh[i] = 1'b1;
        grant_idx   = IDX_W'(i);
        found       = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant_oh[i] = 1'b1;
        grant_idx   = IDX_W'(i);
        found       = 1'b1;
      end
    end
    grant_any = found;
  end

endmodule

// File: rtl/pkt_buffer_write_arbiter.sv
// Round-robin arbiter sharing the single packet-buffer write port among
// NUM_REQ map/dispatch requesters.  A grant is held from a head beat to the
// matching tail beat; a watchdog releases a grant whose owner goes quiet.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   iv_wdata          : one 134b beat per requester, flag in [133:132]
//   iv_data_waddr     : one 16b buffer address per requester
//   iv_data_wr        : per-requester beat valid, held until acked
//   ov_wdata_ack      : per-requester pulse, beat captured this cycle
//   ov_wdata          : registered beat to the packet buffer
//   ov_data_waddr     : registered address to the packet buffer
//   o_data_wr         : beat valid, held until i_wdata_ack
//   i_wdata_ack       : packet buffer accepted the current beat
//   ov_grant          : index of the current / last granted requester
//   o_timeout_pulse   : grant released by the watchdog this cycle
//   o_discard_pulse   : stray non-head beat dropped this cycle
//   arb_state         : FSM state (0 IDLE, 1 XFER)
module pkt_buffer_write_arbiter
  import pkt_buffer_write_arbiter_pkg::*;
#(
  parameter int              NUM_REQ        = 3,
  parameter logic [WD_W-1:0] TIMEOUT_CYCLES = 16'd64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ*BEAT_W-1:0] iv_wdata,
  input  logic [NUM_REQ*ADDR_W-1:0] iv_data_waddr,
  input  logic [NUM_REQ-1:0]        iv_data_wr,
  output logic [NUM_REQ-1:0]        ov_wdata_ack,
  output logic [BEAT_W-1:0]         ov_wdata,
  output logic [ADDR_W-1:0]         ov_data_waddr,
  output logic                      o_data_wr,
  input  logic                      i_wdata_ack,
  output logic [2:0]                ov_grant,
  output logic                      o_timeout_pulse,
  output logic                      o_discard_pulse,
  output logic [1:0]                arb_state
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WD_W-1:0]    wd_q, wd_d, wd_inc;

  logic [NUM_REQ-1:0] head_req, stray_req, stray_oh, sel_oh, grant_oh;
  logic [NUM_REQ-1:0] cap_oh, ack;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any, stray_any, slot_free;
  logic               g_wr;
  logic [1:0]         g_flag;
  logic               discard, timeout;
  logic [BEAT_W-1:0]  cap_beat;
  logic [ADDR_W-1:0]  cap_addr;

  // The output register can take a beat when it is empty or is being
  // drained this same cycle; this makes i_wdata_ack -> ov_wdata_ack
  // combinational, which keeps full throughput without a skid buffer.
  assign slot_free = !o_data_wr || i_wdata_ack;

  // Saturating increment so the counter never wraps back to a small value.
  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);

  // Classify every valid beat as a packet head or a stray (anything else),
  // and decode the current grant into a one-hot mask plus its wr/flag.
  always_comb begin
    head_req  = '0;
    stray_req = '0;
    grant_oh  = '0;
    g_wr      = 1'b0;
    g_flag    = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      head_req[i]  = iv_data_wr[i] && (beat_flag(iv_wdata[i*BEAT_W +: BEAT_W]) == FLAG_HEAD);
      stray_req[i] = iv_data_wr[i] && (beat_flag(iv_wdata[i*BEAT_W +: BEAT_W]) != FLAG_HEAD);
      if (grant_q == IDX_W'(i)) begin
        grant_oh[i] = 1'b1;
        g_wr        = iv_data_wr[i];
        g_flag      = beat_flag(iv_wdata[i*BEAT_W +: BEAT_W]);
      end
    end
  end

  // Strays are dropped one per cycle, lowest index first.
  always_comb begin
    stray_oh  = '0;
    stray_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stray_req[i] && !stray_any) begin
        stray_oh[i] = 1'b1;
        stray_any   = 1'b1;
      end
    end
  end

  pkt_buffer_write_arbiter_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req       (head_req),
    .ptr       (ptr_q),
    .grant_oh  (sel_oh),
    .grant_idx (sel_idx),
    .grant_any (sel_any)
  );

  // Next-state logic.  Everything is gated by reset so no requester sees an
  // ack while the arbiter is being cleared.
  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    cap_oh  = '0;
    ack     = '0;
    discard = 1'b0;
    timeout = 1'b0;
    if (!i_rst) begin
      case (state_q)
        ST_IDLE: begin
          wd_d = '0;
          // Dropping a stray is also held off under backpressure so that no
          // requester is acked while the buffer is stalling the port.
          if (slot_free && stray_any) begin
            ack     = ack | stray_oh;
            discard = 1'b1;
          end
          if (slot_free && sel_any) begin
            cap_oh  = sel_oh;
            ack     = ack | sel_oh;
            grant_d = sel_idx;
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          if (g_wr) begin
            if (slot_free) begin
              cap_oh = grant_oh;
              ack    = grant_oh;
              wd_d   = '0;
              if (g_flag == FLAG_TAIL) begin
                ptr_d   = grant_q;
                state_d = ST_IDLE;
              end
            end
          end else if (wd_inc >= TIMEOUT_CYCLES) begin
            // Owner has been silent long enough: give the port away.  Any
            // beat already in the output register still drains normally.
            timeout = 1'b1;
            ptr_d   = grant_q;
            wd_d    = '0;
            state_d = ST_IDLE;
          end else begin
            wd_d = wd_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Mux the captured requester's beat and address.
  always_comb begin
    cap_beat = '0;
    cap_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cap_oh[i]) begin
        cap_beat = iv_wdata[i*BEAT_W +: BEAT_W];
        cap_addr = iv_data_waddr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Output register: a capture always wins; an ack alone empties it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the beat/address register is reset as well: it is a single
      // beat wide, and the buffer-facing outputs must read zero after reset.
      o_data_wr     <= 1'b0;
      ov_wdata      <= '0;
      ov_data_waddr <= '0;
    end else if (|cap_oh) begin
      o_data_wr     <= 1'b1;
      ov_wdata      <= cap_beat;
      ov_data_waddr <= cap_addr;
    end else if (i_wdata_ack) begin
      o_data_wr     <= 1'b0;
    end
  end

  assign ov_wdata_ack    = ack;
  assign o_timeout_pulse = timeout;
  assign o_discard_pulse = discard;
  assign ov_grant        = grant_q;
  assign arb_state       = state_q;

endmodule

// File: tb/tb_pkt_buffer_write_arbiter.sv
// Self-checking bench for pkt_buffer_write_arbiter: a table of single-cycle
// IDLE decisions, then multi-cycle packet sequences checked by a scoreboard.
module tb_pkt_buffer_write_arbiter;
  import pkt_buffer_write_arbiter_pkg::*;

  localparam int          N   = 3;
  localparam int          NB  = 4;
  localparam logic [15:0] TMO = 16'd8;

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic [N*BEAT_W-1:0]   iv_wdata;
  logic [N*ADDR_W-1:0]   iv_data_waddr;
  logic [N-1:0]          iv_data_wr;
  logic [N-1:0]          ov_wdata_ack;
  logic [BEAT_W-1:0]     ov_wdata;
  logic [ADDR_W-1:0]     ov_data_waddr;
  logic                  o_data_wr;
  logic                  i_wdata_ack;
  logic [2:0]            ov_grant;
  logic                  o_timeout_pulse;
  logic                  o_discard_pulse;
  logic [1:0]            arb_state;

  always #5 i_clk = ~i_clk;

  pkt_buffer_write_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .iv_wdata        (iv_wdata),
    .iv_data_waddr   (iv_data_waddr),
    .iv_data_wr      (iv_data_wr),
    .ov_wdata_ack    (ov_wdata_ack),
    .ov_wdata        (ov_wdata),
    .ov_data_waddr   (ov_data_waddr),
    .o_data_wr       (o_data_wr),
    .i_wdata_ack     (i_wdata_ack),
    .ov_grant        (ov_grant),
    .o_timeout_pulse (o_timeout_pulse),
    .o_discard_pulse (o_discard_pulse),
    .arb_state       (arb_state)
  );

  typedef struct {
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        grant;
    int                cyc;    // -1: any cycle
  } sb_entry_t;

  typedef struct {
    logic [2:0] wr;
    logic [5:0] flags;         // {req2, req1, req0}
    logic [2:0] ack;
    logic       disc;
    logic       wr_nxt;
    logic [2:0] grant_nxt;
    logic [1:0] state_nxt;
  } vec_t;

  sb_entry_t sb_q[$];
  vec_t      vecs[10];

  int checks = 0;
  int errors = 0;
  int cyc, exp_k, tmo_cnt, gaps, tmo_cyc;
  bit sb_en;

  // Requester models
  int pkts_left[N], beat_no[N], pkt_no[N], sent[N], stall_at[N];
  bit stalled[N];

  // Values sampled at the falling edge of the current cycle
  logic [2:0]        s_ack, s_grant;
  logic              s_wr, s_tmo, s_disc;
  logic [1:0]        s_state;
  logic [BEAT_W-1:0] s_data;
  logic [ADDR_W-1:0] s_addr;

  task automatic check(input string name, input logic [149:0] act, input logic [149:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] make_beat(input int r, input int p, input int b);
    logic [BEAT_W-1:0] v;
    logic [1:0]        f;
    if (b == 0)           f = FLAG_HEAD;
    else if (b == NB - 1) f = FLAG_TAIL;
    else                  f = FLAG_MID;
    v = '0;
    v[BEAT_W-1 -: 2] = f;
    v[127:96] = 32'hC0DE_0000 ^ 32'(r * 4096 + p * 64 + b);
    v[31:0]   = {8'(r), 8'(p), 8'(b), 8'hA5};
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] make_addr(input int r, input int p, input int b);
    return 16'(r * 4096 + p * 16 + b);
  endfunction

  // Push the first n beats of packet p of requester r onto the scoreboard.
  task automatic expect_pkt(input int r, input int p, input int n, input bit timed);
    sb_entry_t e;
    for (int b = 0; b < n; b++) begin
      e.beat  = make_beat(r, p, b);
      e.addr  = make_addr(r, p, b);
      e.grant = 3'(r);
      e.cyc   = timed ? exp_k + 1 : -1;
      exp_k++;
      sb_q.push_back(e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 0;
      beat_no[i]   = 0;
      pkt_no[i]    = 0;
      sent[i]      = 0;
      stall_at[i]  = -1;
      stalled[i]   = 1'b0;
    end
  endtask

  task automatic drive();
    bit present;
    for (int i = 0; i < N; i++) begin
      present = (pkts_left[i] > 0) && !stalled[i];
      iv_data_wr[i] = present;
      iv_wdata[i*BEAT_W +: BEAT_W]      = present ? make_beat(i, pkt_no[i], beat_no[i]) : '0;
      iv_data_waddr[i*ADDR_W +: ADDR_W] = present ? make_addr(i, pkt_no[i], beat_no[i]) : '0;
    end
  endtask

  // One clock cycle: drive after the rising edge, sample/score at the
  // falling edge, advance requester models on their acks.
  task automatic step();
    sb_entry_t e;
    drive();
    @(negedge i_clk);
    s_ack   = ov_wdata_ack;
    s_wr    = o_data_wr;
    s_tmo   = o_timeout_pulse;
    s_disc  = o_discard_pulse;
    s_state = arb_state;
    s_grant = ov_grant;
    s_data  = ov_wdata;
    s_addr  = ov_data_waddr;
    if (sb_en && o_data_wr && i_wdata_ack) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_beat", o_data_wr, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("sb_beat_addr", {ov_wdata, ov_data_waddr}, {e.beat, e.addr});
        check("sb_grant", ov_grant, e.grant);
        if (e.cyc >= 0) check("sb_cycle", cyc, e.cyc);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (s_ack[i] && iv_data_wr[i]) begin
        sent[i]++;
        beat_no[i]++;
        if (beat_no[i] == NB) begin
          beat_no[i] = 0;
          pkt_no[i]++;
          pkts_left[i]--;
        end
        if (sent[i] == stall_at[i]) stalled[i] = 1'b1;
      end
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    i_wdata_ack = 1'b1;
    model_clear();
    drive();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    sb_q.delete();
    cyc     = 0;
    exp_k   = 0;
    tmo_cnt = 0;
    gaps    = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    bit seen;
    c    = 0;
    seen = 1'b0;
    while (sb_q.size() > 0 && c < budget) begin
      step();
      c++;
      if (s_tmo) tmo_cnt++;
      if (s_wr && i_wdata_ack) seen = 1'b1;
      else if (seen && sb_q.size() > 0) gaps++;
    end
    check({name, "_drain"}, sb_q.size(), 0);
  endtask

  initial begin
    logic [BEAT_W-1:0] vb;

    //              wr      flags {r2,r1,r0}                 ack     disc  wr+  grant+ state+
    vecs[0] = '{3'b001, {2'b00, 2'b00, FLAG_HEAD},     3'b001, 1'b0, 1'b1, 3'd0, 2'd1};
    vecs[1] = '{3'b010, {2'b00, FLAG_MID, 2'b00},      3'b010, 1'b1, 1'b0, 3'd0, 2'd0};
    vecs[2] = '{3'b110, {FLAG_TAIL, FLAG_HEAD, 2'b00}, 3'b110, 1'b1, 1'b1, 3'd1, 2'd1};
    vecs[3] = '{3'b111, {FLAG_HEAD, FLAG_HEAD, FLAG_HEAD}, 3'b001, 1'b0, 1'b1, 3'd0, 2'd1};
    vecs[4] = '{3'b000, {FLAG_HEAD, FLAG_HEAD, FLAG_HEAD}, 3'b000, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[5] = '{3'b110, {FLAG_HEAD, FLAG_HEAD, 2'b00}, 3'b010, 1'b0, 1'b1, 3'd1, 2'd1};
    vecs[6] = '{3'b101, {FLAG_TAIL, 2'b00, FLAG_MID},  3'b001, 1'b1, 1'b0, 3'd0, 2'd0};
    vecs[7] = '{3'b011, {2'b00, FLAG_MID, FLAG_TAIL},  3'b001, 1'b1, 1'b0, 3'd0, 2'd0};
    vecs[8] = '{3'b100, {2'b00, 2'b00, 2'b00},         3'b100, 1'b1, 1'b0, 3'd0, 2'd0};
    vecs[9] = '{3'b101, {FLAG_HEAD, 2'b00, FLAG_MID},  3'b101, 1'b1, 1'b1, 3'd2, 2'd1};

    sb_en         = 1'b0;
    i_wdata_ack   = 1'b1;
    iv_wdata      = '0;
    iv_data_waddr = '0;
    iv_data_wr    = '0;

    // Reset state
    do_reset();
    step();
    check("rst_data_wr", s_wr, 1'b0);
    check("rst_state", s_state, 2'd0);
    check("rst_grant", s_grant, 3'd0);
    check("rst_beat_addr", {s_data, s_addr}, 150'd0);
    check("rst_pulses", {s_ack, s_tmo, s_disc}, 5'd0);

    // Single-cycle IDLE decisions from a fresh reset (pointer = NUM_REQ-1)
    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        vb = '0;
        vb[BEAT_W-1 -: 2] = vecs[v].flags[2*i +: 2];
        vb[15:0] = 16'(v * 16 + i);
        iv_wdata[i*BEAT_W +: BEAT_W]      = vb;
        iv_data_waddr[i*ADDR_W +: ADDR_W] = 16'(v * 16 + i);
        iv_data_wr[i] = vecs[v].wr[i];
      end
      @(negedge i_clk);
      check($sformatf("vec%0d_ack", v), ov_wdata_ack, vecs[v].ack);
      check($sformatf("vec%0d_discard", v), o_discard_pulse, vecs[v].disc);
      @(posedge i_clk);
      #1;
      iv_data_wr = '0;
      @(negedge i_clk);
      check($sformatf("vec%0d_data_wr", v), o_data_wr, vecs[v].wr_nxt);
      check($sformatf("vec%0d_grant", v), ov_grant, vecs[v].grant_nxt);
      check($sformatf("vec%0d_state", v), arb_state, vecs[v].state_nxt);
      @(posedge i_clk);
      #1;
    end

    sb_en = 1'b1;

    // Two heads together after reset: req0 on cycles 1-4, req1 on 5-8
    do_reset();
    pkts_left[0] = 1;
    pkts_left[1] = 1;
    expect_pkt(0, 0, NB, 1'b1);
    expect_pkt(1, 0, NB, 1'b1);
    drain("t1", 40);

    // Backpressure while granted to req2
    do_reset();
    pkts_left[2] = 1;
    expect_pkt(2, 0, NB, 1'b0);
    step();
    check("t2_head_ack", s_ack, 3'b100);
    step();
    i_wdata_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_bp_data_wr", s_wr, 1'b1);
      check("t2_bp_beat_addr", {s_data, s_addr}, {make_beat(2, 0, 1), make_addr(2, 0, 1)});
      check("t2_bp_ack", s_ack, 3'b000);
    end
    i_wdata_ack = 1'b1;
    drain("t2", 40);

    // Watchdog: req1 stops after two beats, req2 head waiting
    do_reset();
    pkts_left[1] = 1;
    stall_at[1]  = 2;
    pkts_left[2] = 1;
    expect_pkt(1, 0, 2, 1'b0);
    expect_pkt(2, 0, NB, 1'b0);
    tmo_cyc = -1;
    for (int c = 0; c < 40 && tmo_cyc < 0; c++) begin
      step();
      if (s_tmo) begin
        tmo_cyc = cyc - 1;
        tmo_cnt++;
        check("t3_tmo_ack", s_ack, 3'b000);
      end
    end
    check("t3_tmo_cycle", tmo_cyc, 9);
    step();
    check("t3_next_head_ack", s_ack, 3'b100);
    drain("t3", 40);
    check("t3_tmo_count", tmo_cnt, 1);

    // Reset in the middle of req0's packet
    do_reset();
    pkts_left[0] = 1;
    pkts_left[1] = 1;
    expect_pkt(0, 0, 1, 1'b0);
    step();
    step();
    i_rst        = 1'b1;
    i_wdata_ack  = 1'b0;
    pkts_left[0] = 0;
    step();
    check("t5_rst_ack", s_ack, 3'b000);
    i_rst       = 1'b0;
    i_wdata_ack = 1'b1;
    check("t5_pre_rst_beats", sb_q.size(), 0);
    expect_pkt(1, 0, NB, 1'b0);
    step();
    check("t5_post_data_wr", s_wr, 1'b0);
    check("t5_post_beat_addr", {s_data, s_addr}, 150'd0);
    check("t5_post_state", s_state, 2'd0);
    check("t5_post_grant", s_grant, 3'd0);
    check("t5_req1_ack", s_ack, 3'b010);
    drain("t5", 40);

    // All requesters streaming: order 0,1,2,0,1,2 with no gaps
    do_reset();
    for (int i = 0; i < N; i++) pkts_left[i] = 2;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++)
        expect_pkt(r, p, NB, 1'b1);
    drain("t6", 80);
    check("t6_gaps", gaps, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
